// File: rtl/load_align_pkg.sv
// Shared load/store definitions: funct3 encodings, region map and load-path state.
package load_align_pkg;

  localparam logic [2:0] FNC_LB  = 3'd0;
  localparam logic [2:0] FNC_LH  = 3'd1;
  localparam logic [2:0] FNC_LW  = 3'd2;
  localparam logic [2:0] FNC_LBU = 3'd4;
  localparam logic [2:0] FNC_LHU = 3'd5;

  localparam logic [3:0]  BIOS_PREFIX = 4'b0100;
  localparam int unsigned MMIO_BIT    = 31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_MMIO,
    S_HOLD
  } state_t;

  // Misaligned or illegal load encoding; such loads never reach memory or MMIO.
  function automatic logic ld_bad(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      FNC_LB, FNC_LBU: ld_bad = 1'b0;
      FNC_LH, FNC_LHU: ld_bad = off[0];
      FNC_LW:          ld_bad = (off != 2'b00);
      default:         ld_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Byte/half/word selection with sign or zero extension; faulted loads yield zero.
module load_extract
  import load_align_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    bad = ld_bad(funct3, offset);
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = '0;
    case (funct3)
      FNC_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: data = {24'd0, byte_sel};
      FNC_LH:  data = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: data = {16'd0, half_sel};
      FNC_LW:  data = word;
      default: data = '0;
    endcase
    if (bad) data = '0;
  end

endmodule

// File: rtl/load_align.sv
// Load-return unit: captures issued loads, waits on BIOS/DMEM/MMIO, aligns and
// presents the extended result for writeback, holding it across downstream stalls.
module load_align
  import load_align_pkg::*;
#(
  parameter int unsigned MMIO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic        stall,
  input  logic [31:0] bios_doutb,
  input  logic [31:0] dmem_douta,
  output logic        mmio_req,
  output logic [31:0] mmio_addr,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ack,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ld_fault
);

  localparam logic [7:0] TO_LAST = 8'(MMIO_TIMEOUT - 1);

  state_t      state;
  logic [31:0] cap_addr;
  logic [2:0]  cap_funct3;
  logic [4:0]  cap_rd;
  logic [7:0]  cnt;
  logic [31:0] hold_data;
  logic        hold_fault;
  logic [4:0]  hold_rd;

  logic [31:0] mem_word;
  logic [31:0] ext_data;
  logic        ext_bad;
  logic [31:0] res_data;
  logic        res_fault;
  logic        timeout;
  logic        resp_now;
  logic        accept;
  state_t      req_state;

  load_extract u_extract (
    .word   (mem_word),
    .offset (cap_addr[1:0]),
    .funct3 (cap_funct3),
    .data   (ext_data),
    .bad    (ext_bad)
  );

  always_comb begin
    mem_word = dmem_douta;
    if (cap_addr[31:28] == BIOS_PREFIX) mem_word = bios_doutb;
    else if (cap_addr[MMIO_BIT])        mem_word = mmio_rdata;

    timeout   = (state == S_MMIO) && !mmio_ack && (cnt >= TO_LAST);
    resp_now  = (state == S_MEM) || ((state == S_MMIO) && (mmio_ack || timeout));
    res_data  = timeout ? '0 : ext_data;
    res_fault = timeout || ext_bad;

    // A stalled result blocks issue too: accepting then would lose the next load's dout.
    busy   = (state == S_MMIO) || (((state == S_MEM) || (state == S_HOLD)) && stall);
    accept = req_valid && !busy;
    req_state = (req_addr[MMIO_BIT] && !ld_bad(req_funct3, req_addr[1:0])) ? S_MMIO : S_MEM;

    mmio_req  = (state == S_MMIO);
    mmio_addr = cap_addr;

    wb_valid = resp_now || (state == S_HOLD);
    wb_rd    = (state == S_HOLD) ? hold_rd : cap_rd;
    wb_data  = '0;
    ld_fault = 1'b0;
    if (state == S_HOLD) begin
      wb_data  = hold_data;
      ld_fault = hold_fault;
    end else if (resp_now) begin
      wb_data  = res_data;
      ld_fault = res_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_rd     <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_fault <= 1'b0;
      hold_rd    <= '0;
    end else begin
      if (accept) begin
        cap_addr   <= req_addr;
        cap_funct3 <= req_funct3;
        cap_rd     <= req_rd;
        cnt        <= '0;
      end
      if (resp_now && stall) begin
        hold_data  <= res_data;
        hold_fault <= res_fault;
        hold_rd    <= cap_rd;
      end
      unique case (state)
        S_IDLE: if (accept) state <= req_state;
        S_MEM: begin
          if (stall)       state <= S_HOLD;
          else if (accept) state <= req_state;
          else             state <= S_IDLE;
        end
        S_MMIO: begin
          if (mmio_ack || timeout) state <= stall ? S_HOLD : S_IDLE;
          else                     cnt   <= cnt + 8'd1;
        end
        S_HOLD: begin
          if (!stall) state <= accept ? req_state : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
